// File: rtl/prores_vlc_pkg.sv
// prores_vlc_pkg: codebook table and field helpers shared by the ProRes AC run and level encoders.
package prores_vlc_pkg;

    localparam logic [7:0] AC_RUN_CB [16] = '{
        8'h06, 8'h06, 8'h05, 8'h05, 8'h04, 8'h29, 8'h29, 8'h29,
        8'h29, 8'h28, 8'h28, 8'h28, 8'h28, 8'h28, 8'h28, 8'h4C
    };

    function automatic logic [2:0] cb_rice(input logic [7:0] cb);
        return cb[7:5];
    endfunction

    function automatic logic [2:0] cb_exp(input logic [7:0] cb);
        return cb[4:2];
    endfunction

    function automatic logic [1:0] cb_switch(input logic [7:0] cb);
        return cb[1:0];
    endfunction

    function automatic logic [4:0] log2_floor(input logic [31:0] v);
        log2_floor = '0;
        for (int i = 0; i < 32; i++)
            if (v[i]) log2_floor = 5'(i);
    endfunction

endpackage

// File: rtl/adaptive_vlc_codeword.sv
// adaptive_vlc_codeword: two-stage Rice/exp-Golomb codeword builder (S2 registered, S3 assembled
// combinationally so the caller can register it together with its own framing bits).
module adaptive_vlc_codeword
    import prores_vlc_pkg::*;
#(
    parameter int RUN_W  = 12,
    parameter int CODE_W = 32,
    parameter int LEN_W  = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic [RUN_W-1:0]  n,
    input  logic [7:0]        cb,
    output logic [CODE_W-1:0] code,
    output logic [LEN_W-1:0]  len
);

    localparam int VW      = RUN_W + 2;
    localparam int MAX_LEN = 2 * RUN_W + 4;

    if (MAX_LEN > CODE_W || MAX_LEN >= 2 ** LEN_W || VW > 32) begin : g_width_check
        $error("adaptive_vlc_codeword: worst-case codeword does not fit CODE_W/LEN_W");
    end

    logic [2:0]    r, e;
    logic [1:0]    s;
    logic [VW-1:0] nx, t, v;
    logic          s2_rice;
    logic [2:0]    s2_r, s2_e;
    logic [1:0]    s2_s;
    logic [VW-1:0] s2_nx, s2_v, mask, q;
    logic [4:0]    s2_x;

    always_comb begin
        r  = cb_rice(cb);
        e  = cb_exp(cb);
        s  = cb_switch(cb);
        nx = VW'(n);
        t  = VW'(3'(s) + 3'd1) << r;
        v  = nx - t + (VW'(1) << e);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_rice <= 1'b0;
            s2_r    <= '0;
            s2_e    <= '0;
            s2_s    <= '0;
            s2_nx   <= '0;
            s2_v    <= '0;
            s2_x    <= '0;
        end else if (en) begin
            s2_rice <= nx < t;
            s2_r    <= r;
            s2_e    <= e;
            s2_s    <= s;
            s2_nx   <= nx;
            s2_v    <= v;
            s2_x    <= log2_floor(32'(v));
        end
    end

    // Rice: unary quotient of zeros, stop bit, then r low bits of n.
    always_comb begin
        mask = VW'(1) << s2_r;
        q    = s2_nx >> s2_r;
        code = s2_rice ? CODE_W'(mask | (s2_nx & (mask - VW'(1)))) : CODE_W'(s2_v);
        len  = s2_rice ? LEN_W'(q) + LEN_W'(s2_r) + LEN_W'(1)
                       : LEN_W'(2 * s2_x) - LEN_W'(s2_e) + LEN_W'(s2_s) + LEN_W'(1);
    end

endmodule

// File: rtl/entropy_encode_ac_run_adaptive.sv
// entropy_encode_ac_run_adaptive: AC zero-run encoder; counts zero runs, picks the codebook from the
// previous run and emits one codeword per non-zero coefficient through a 3-stage stallable pipeline.
module entropy_encode_ac_run_adaptive
    import prores_vlc_pkg::*;
#(
    parameter int COEFF_W = 20,
    parameter int RUN_W   = 12,
    parameter int CODE_W  = 32,
    parameter int LEN_W   = 6
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COEFF_W-1:0] in_coeff,
    input  logic               in_sos,
    input  logic               in_eos,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CODE_W-1:0]  out_code,
    output logic [LEN_W-1:0]   out_len,
    output logic               out_last,
    output logic               err_run_ovf
);

    localparam logic [RUN_W-1:0] RUN_MAX   = '1;
    localparam logic [RUN_W-1:0] PREV_INIT = RUN_W'(4);

    logic              en, acc, nz, run_sat;
    logic [RUN_W-1:0]  run, prev_run, run_cur, prev_cur;
    logic [3:0]        cb_idx;
    logic              s1_valid, s1_mark, s1_last, s2_valid, s2_mark, s2_last;
    logic [RUN_W-1:0]  s1_n;
    logic [7:0]        s1_cb;
    logic [CODE_W-1:0] cw_code;
    logic [LEN_W-1:0]  cw_len;

    always_comb begin
        en       = ~out_valid | out_ready;
        in_ready = en;
        acc      = in_valid & en;
        nz       = in_coeff != '0;
        run_cur  = in_sos ? '0 : run;
        prev_cur = in_sos ? PREV_INIT : prev_run;
        run_sat  = run_cur == RUN_MAX;
        cb_idx   = (prev_cur > RUN_W'(15)) ? 4'd15 : prev_cur[3:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run         <= '0;
            prev_run    <= PREV_INIT;
            err_run_ovf <= 1'b0;
            s1_valid    <= 1'b0;
            s1_mark     <= 1'b0;
            s1_last     <= 1'b0;
            s1_n        <= '0;
            s1_cb       <= '0;
            s2_valid    <= 1'b0;
            s2_mark     <= 1'b0;
            s2_last     <= 1'b0;
            out_valid   <= 1'b0;
            out_code    <= '0;
            out_len     <= '0;
            out_last    <= 1'b0;
        end else if (en) begin
            // Trailing zeros only surface as a zero-length marker when they close the slice.
            s1_valid <= acc & (nz | in_eos);
            s1_mark  <= ~nz;
            s1_last  <= in_eos;
            s1_n     <= run_cur;
            s1_cb    <= AC_RUN_CB[cb_idx];
            if (acc) begin
                run      <= nz ? '0 : (run_sat ? run_cur : run_cur + RUN_W'(1));
                prev_run <= nz ? run_cur : prev_cur;
                if (!nz && run_sat) err_run_ovf <= 1'b1;
            end
            s2_valid  <= s1_valid;
            s2_mark   <= s1_mark;
            s2_last   <= s1_last;
            out_valid <= s2_valid;
            out_last  <= s2_valid & s2_last;
            out_code  <= (s2_valid & ~s2_mark) ? cw_code : '0;
            out_len   <= (s2_valid & ~s2_mark) ? cw_len : '0;
        end
    end

    adaptive_vlc_codeword #(
        .RUN_W (RUN_W),
        .CODE_W(CODE_W),
        .LEN_W (LEN_W)
    ) u_codeword (
        .clk    (clk),
        .reset_n(reset_n),
        .en     (en),
        .n      (s1_n),
        .cb     (s1_cb),
        .code   (cw_code),
        .len    (cw_len)
    );

endmodule

// File: tb/tb_entropy_encode_ac_run_adaptive.sv
// tb_entropy_encode_ac_run_adaptive: directed and randomised-handshake checks of the AC run encoder,
// with a second RUN_W=4 instance sharing the stimulus for run saturation.
module tb_entropy_encode_ac_run_adaptive;

    logic clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, in_sos = 1'b0, in_eos = 1'b0, out_ready = 1'b1;
    logic signed [19:0] in_coeff = '0;
    logic        in_ready, out_valid, out_last, err_run_ovf;
    logic [31:0] out_code;
    logic [5:0]  out_len;
    logic        in_ready4, out_valid4, out_last4, err_run_ovf4;
    logic [31:0] out_code4;
    logic [5:0]  out_len4;

    int checks = 0, failures = 0;
    int mrun = 0, mprev = 4;
    bit rnd_ready = 1'b0, chk_ready = 1'b0;
    logic [38:0] got_q[$], got4_q[$], exp_q[$];

    localparam logic [7:0] CB [16] = '{
        8'h06, 8'h06, 8'h05, 8'h05, 8'h04, 8'h29, 8'h29, 8'h29,
        8'h29, 8'h28, 8'h28, 8'h28, 8'h28, 8'h28, 8'h28, 8'h4C
    };

    always #5 clk = ~clk;

    entropy_encode_ac_run_adaptive dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_coeff(in_coeff),
        .in_sos(in_sos), .in_eos(in_eos), .out_valid(out_valid), .out_ready(out_ready),
        .out_code(out_code), .out_len(out_len), .out_last(out_last), .err_run_ovf(err_run_ovf)
    );

    entropy_encode_ac_run_adaptive #(.RUN_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready4), .in_coeff(in_coeff),
        .in_sos(in_sos), .in_eos(in_eos), .out_valid(out_valid4), .out_ready(out_ready),
        .out_code(out_code4), .out_len(out_len4), .out_last(out_last4), .err_run_ovf(err_run_ovf4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [38:0] beat(input logic last, input int len, input int code);
        return {last, 6'(len), 32'(code)};
    endfunction

    // Independent codeword model: Rice below the switch threshold, exp-Golomb above it.
    function automatic logic [38:0] model(input int n, input int p, input logic last);
        logic [7:0] c;
        int r, e, s, t, v, x;
        c = CB[p > 15 ? 15 : p];
        r = int'(c[7:5]);
        e = int'(c[4:2]);
        s = int'(c[1:0]);
        t = (s + 1) << r;
        if (n < t) return beat(last, (n >> r) + 1 + r, (1 << r) | (n & ((1 << r) - 1)));
        v = n - t + (1 << e);
        x = 0;
        while ((v >> (x + 1)) != 0) x++;
        return beat(last, 2 * x - e + s + 1, v);
    endfunction

    initial begin
        logic [38:0] held;
        bit stalled;
        stalled = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) stalled = 1'b0;
            else begin
                if (stalled) check("hold", {out_last, out_len, out_code}, held);
                if (chk_ready) check("in_ready", in_ready, !out_valid || out_ready);
                if (out_valid && out_ready) got_q.push_back({out_last, out_len, out_code});
                if (out_valid4 && out_ready) got4_q.push_back({out_last4, out_len4, out_code4});
                stalled = out_valid && !out_ready;
                held = {out_last, out_len, out_code};
            end
        end
    end

    initial begin
        int stall;
        stall = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) begin
                if (stall > 0) begin
                    out_ready = 1'b0;
                    stall--;
                end else if ($urandom_range(0, 15) == 0) begin
                    out_ready = 1'b0;
                    stall = 7;
                end else out_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic send(input logic signed [19:0] c, input logic sos, input logic eos);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_coeff = c;
        in_sos = sos;
        in_eos = eos;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sos = 1'b0;
        in_eos = 1'b0;
        if (sos) begin
            mrun = 0;
            mprev = 4;
        end
        if (c != 0) begin
            exp_q.push_back(model(mrun, mprev, eos));
            mprev = mrun;
            mrun = 0;
        end else begin
            if (eos) exp_q.push_back(beat(1'b1, 0, 0));
            if (mrun < 4095) mrun++;
        end
    endtask

    task automatic wait_beats(input int n);
        int t;
        t = 0;
        while (got_q.size() < n && t < 300) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        check("beat_count", got_q.size(), n);
        @(posedge clk);
        #1;
    endtask

    task automatic compare_model(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        foreach (exp_q[i])
            if (i < got_q.size()) check($sformatf("%s_beat%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        in_valid = 1'b0;
        in_sos = 1'b0;
        in_eos = 1'b0;
        got_q.delete();
        got4_q.delete();
        exp_q.delete();
        mrun = 0;
        mprev = 4;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int v;
        bit eos, sos_next;
        // T1: reset state, with downstream stalled so in_ready must still be high
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("t1_out_valid", out_valid, 0);
        check("t1_out_len", out_len, 0);
        check("t1_out_code", out_code, 0);
        check("t1_out_last", out_last, 0);
        check("t1_err", err_run_ovf, 0);
        check("t1_in_ready", in_ready, 1);
        out_ready = 1'b1;

        // T2: latency and first two codewords
        do_reset();
        send(20'sd5, 1'b1, 1'b0);
        @(negedge clk) check("t2_lat1", out_valid, 0);
        @(negedge clk) check("t2_lat2", out_valid, 0);
        @(negedge clk) check("t2_lat3", out_valid, 1);
        check("t2_lat3_beat", {out_last, out_len, out_code}, beat(1'b0, 1, 1));
        @(posedge clk);
        #1;
        send(20'sd0, 1'b0, 1'b0);
        send(20'sd0, 1'b0, 1'b0);
        send(-20'sd3, 1'b0, 1'b0);
        wait_beats(2);
        check("t2_beat0", got_q[0], beat(1'b0, 1, 1));
        check("t2_beat1", got_q[1], beat(1'b0, 3, 1));
        compare_model("t2");

        // T3: exp-Golomb branch
        do_reset();
        send(20'sd9, 1'b1, 1'b0);
        repeat (5) send(20'sd0, 1'b0, 1'b0);
        send(20'sd1, 1'b0, 1'b0);
        wait_beats(2);
        check("t3_beat1", got_q[1], beat(1'b0, 6, 4));
        compare_model("t3");

        // T5: trailing run dropped, marker, then sos restores prev_run=4
        do_reset();
        send(20'sd7, 1'b1, 1'b0);
        send(20'sd0, 1'b0, 1'b0);
        send(20'sd0, 1'b0, 1'b0);
        send(20'sd0, 1'b0, 1'b1);
        send(20'sd3, 1'b1, 1'b0);
        wait_beats(3);
        check("t5_beat0", got_q[0], beat(1'b0, 1, 1));
        check("t5_marker", got_q[1], beat(1'b1, 0, 0));
        check("t5_sos_ctx", got_q[2], beat(1'b0, 1, 1));
        compare_model("t5");

        // T4: random stream under random backpressure and 8-clk stalls
        do_reset();
        chk_ready = 1'b1;
        rnd_ready = 1'b1;
        sos_next = 1'b1;
        for (int i = 0; i < 120; i++) begin
            v = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 500));
            if ($urandom_range(0, 1) == 1) v = -v;
            eos = ($urandom_range(0, 19) == 0);
            send(20'(v), sos_next, eos);
            sos_next = eos;
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        wait_beats(exp_q.size());
        chk_ready = 1'b0;
        compare_model("t4");

        // T6: run saturation on the RUN_W=4 instance, single-beat slices
        do_reset();
        send(20'sd0, 1'b1, 1'b0);
        repeat (19) send(20'sd0, 1'b0, 1'b0);
        send(20'sd2, 1'b0, 1'b0);
        send(20'sd4, 1'b1, 1'b1);
        send(20'sd0, 1'b1, 1'b1);
        wait_beats(3);
        check("t6_wide_n20", got_q[0], beat(1'b0, 8, 21));
        check("t6_wide_err", err_run_ovf, 0);
        check("t6_sat_count", got4_q.size(), 3);
        check("t6_sat_n15", got4_q[0], beat(1'b0, 8, 16));
        check("t6_single_nz", got4_q[1], beat(1'b1, 1, 1));
        check("t6_single_zero", got4_q[2], beat(1'b1, 0, 0));
        check("t6_sat_err", err_run_ovf4, 1);
        compare_model("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired got=running expected=finished");
        $fatal(1);
    end

endmodule
